// File: rtl/imem_pkg.sv
// imem_pkg: phase encodings, NOP constant and word-address check shared by the imem controller
package imem_pkg;

    typedef enum logic [1:0] {
        PH_CLEAR = 2'd0,
        PH_LOAD  = 2'd1,
        PH_RUN   = 2'd2
    } phase_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Compares the whole 32-bit address so high bits can never alias into range
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// imem_addr_check: byte address to word index plus misaligned/out-of-range flag
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic [31:0]       addr,
    output logic [ADDR_W-1:0] idx,
    output logic              bad
);

    assign idx = addr[ADDR_W+1:2];
    assign bad = addr_bad(addr, DEPTH);

endmodule

// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: sequences the imem port through clear, load and run, giving loader writes priority over fetch
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH          = 1024,
    parameter int          ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] NOP_INSTR      = imem_pkg::NOP_INSTR
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    output logic              cpu_fault,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              ld_restart,
    output logic              ld_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        phase
);

    localparam phase_e          PH_START = CLEAR_ON_RESET ? PH_CLEAR : PH_LOAD;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    phase_e            phase_q, phase_nxt;
    logic [ADDR_W:0]   clr_cnt, clr_nxt;
    logic              err_q, err_nxt;
    logic [ADDR_W-1:0] cpu_idx, ld_idx;
    logic              cpu_bad, ld_bad;

    imem_addr_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_cpu_chk (
        .addr (cpu_pc),
        .idx  (cpu_idx),
        .bad  (cpu_bad)
    );

    imem_addr_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ld_chk (
        .addr (ld_addr),
        .idx  (ld_idx),
        .bad  (ld_bad)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            phase_q <= PH_START;
            clr_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            clr_cnt <= clr_nxt;
            err_q   <= err_nxt;
        end
    end

    // Outputs are gated by the reset pin so they go quiet without waiting for a clock
    always_comb begin
        phase_nxt = phase_q;
        clr_nxt   = clr_cnt;
        err_nxt   = err_q;
        cpu_instr = NOP_INSTR;
        cpu_stall = 1'b1;
        cpu_fault = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (SYS_reset) begin
            case (phase_q)
                PH_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_addr  = clr_cnt[ADDR_W-1:0];
                    clr_nxt   = clr_cnt + 1'b1;
                    phase_nxt = (clr_cnt == CLR_LAST) ? PH_LOAD : PH_CLEAR;
                end
                PH_LOAD: begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
                        mem_we    = !ld_bad;
                        mem_addr  = ld_idx;
                        mem_wdata = ld_data;
                        err_nxt   = err_q | ld_bad;
                        phase_nxt = ld_last ? PH_RUN : PH_LOAD;
                    end
                end
                PH_RUN: begin
                    if (ld_valid && !ld_restart) begin
                        ld_ready  = 1'b1;
                        mem_we    = !ld_bad;
                        mem_addr  = ld_idx;
                        mem_wdata = ld_data;
                        err_nxt   = err_q | ld_bad;
                    end else begin
                        mem_addr  = cpu_idx;
                        cpu_stall = 1'b0;
                        cpu_fault = cpu_bad;
                        cpu_instr = cpu_bad ? NOP_INSTR : mem_rdata;
                    end
                    if (ld_restart) begin
                        phase_nxt = PH_START;
                        clr_nxt   = '0;
                        err_nxt   = 1'b0;
                    end
                end
                default: phase_nxt = PH_START;
            endcase
        end
    end

    assign ld_err = err_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb_imem_access_ctrl: directed checks of clear, load, run, patch, restart and async reset with DEPTH=16
module tb_imem_access_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              SYS_clk = 1'b0;
    logic              SYS_reset;
    logic [31:0]       cpu_pc, cpu_instr;
    logic              cpu_stall, cpu_fault;
    logic              ld_valid, ld_ready, ld_last, ld_restart, ld_err;
    logic [31:0]       ld_addr, ld_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [1:0]        phase;
    logic [31:0]       mem [DEPTH];
    int                n_chk = 0;
    int                n_pass = 0;

    imem_access_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1), .NOP_INSTR(NOP)) dut (
        .SYS_clk    (SYS_clk),
        .SYS_reset  (SYS_reset),
        .cpu_pc     (cpu_pc),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .cpu_fault  (cpu_fault),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_restart (ld_restart),
        .ld_err     (ld_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .phase      (phase)
    );

    always #5 SYS_clk = ~SYS_clk;

    // Array model: combinational read, synchronous write
    assign mem_rdata = mem[mem_addr];
    always @(posedge SYS_clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge SYS_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD0000 | i;
        SYS_reset = 1'b0;
        cpu_pc = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; ld_restart = 1'b0;
        #12;
        chk("rst_stall", cpu_stall, 1);
        chk("rst_instr", cpu_instr, NOP);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_phase", phase, 0);
        chk("rst_err", ld_err, 0);
        SYS_reset = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("clr_we", mem_we, 1);
            chk("clr_addr", mem_addr, i);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_stall", cpu_stall, 1);
            chk("clr_ready", ld_ready, 0);
            tick();
        end
        chk("load_phase", phase, 1);
        chk("load_ready", ld_ready, 1);
        chk("load_stall", cpu_stall, 1);
        chk("load_instr", cpu_instr, NOP);
        ld_valid = 1'b1; ld_addr = 32'h2; ld_data = 32'hFFFF0000;
        #1;
        chk("bad_misalign_we", mem_we, 0);
        chk("bad_ready", ld_ready, 1);
        tick();
        chk("bad_err", ld_err, 1);
        chk("bad_phase", phase, 1);
        ld_addr = 32'h40;
        #1;
        chk("bad_range_we", mem_we, 0);
        tick();
        ld_addr = 32'h0; ld_data = 32'hAAAA0001;
        #1;
        chk("ld0_we", mem_we, 1);
        chk("ld0_addr", mem_addr, 0);
        chk("ld0_data", mem_wdata, 32'hAAAA0001);
        tick();
        ld_addr = 32'h4; ld_data = 32'hBBBB0002; ld_last = 1'b1;
        #1;
        chk("ld1_we", mem_we, 1);
        chk("ld1_addr", mem_addr, 1);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0; cpu_pc = 32'h4;
        #1;
        chk("run_phase", phase, 2);
        chk("run_instr4", cpu_instr, 32'hBBBB0002);
        chk("run_stall", cpu_stall, 0);
        chk("run_fault", cpu_fault, 0);
        chk("run_ready", ld_ready, 0);
        cpu_pc = 32'h0;
        #1;
        chk("run_instr0", cpu_instr, 32'hAAAA0001);
        cpu_pc = 32'h8;
        #1;
        chk("run_cleared", cpu_instr, 0);
        cpu_pc = 32'h3C;
        #1;
        chk("run_top_fault", cpu_fault, 0);
        chk("run_top_word", cpu_instr, 0);
        cpu_pc = 32'h40;
        #1;
        chk("range_fault", cpu_fault, 1);
        chk("range_instr", cpu_instr, NOP);
        chk("range_stall", cpu_stall, 0);
        cpu_pc = 32'h2;
        #1;
        chk("misalign_fault", cpu_fault, 1);
        cpu_pc = 32'h80000000;
        #1;
        chk("high_bit_fault", cpu_fault, 1);
        chk("high_bit_instr", cpu_instr, NOP);
        cpu_pc = 32'h0; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h12345678;
        #1;
        chk("patch_stall", cpu_stall, 1);
        chk("patch_instr", cpu_instr, NOP);
        chk("patch_fault", cpu_fault, 0);
        chk("patch_ready", ld_ready, 1);
        chk("patch_we", mem_we, 1);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("patch_refetch", cpu_instr, 32'h12345678);
        chk("patch_unstall", cpu_stall, 0);
        ld_valid = 1'b1; ld_addr = 32'h4; ld_data = 32'h11111111; ld_last = 1'b1;
        #1;
        chk("burst1_stall", cpu_stall, 1);
        tick();
        ld_addr = 32'h8; ld_data = 32'h22222222; ld_last = 1'b0;
        #1;
        chk("burst2_stall", cpu_stall, 1);
        chk("burst_last_ignored", phase, 2);
        tick();
        ld_valid = 1'b0; cpu_pc = 32'h8;
        #1;
        chk("burst_readback", cpu_instr, 32'h22222222);
        chk("burst_phase", phase, 2);
        ld_restart = 1'b1; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hCAFEF00D;
        #1;
        chk("restart_ready", ld_ready, 0);
        chk("restart_we", mem_we, 0);
        chk("restart_err_before", ld_err, 1);
        tick();
        ld_restart = 1'b0; ld_valid = 1'b0;
        #1;
        chk("restart_phase", phase, 0);
        chk("restart_err", ld_err, 0);
        chk("restart_nowrite", mem[0], 32'h12345678);
        chk("restart_clr_addr", mem_addr, 0);
        chk("restart_clr_we", mem_we, 1);
        for (int k = 0; k < 3; k++) tick();
        chk("restart_clr_addr3", mem_addr, 3);
        for (int k = 0; k < 40 && phase != 2'd1; k++) tick();
        chk("reload_phase", phase, 1);
        ld_valid = 1'b1; ld_addr = 32'hC; ld_data = 32'h5A5A5A5A;
        #1;
        chk("reload_we", mem_we, 1);
        chk("reload_addr", mem_addr, 3);
        SYS_reset = 1'b0;
        #1;
        chk("async_we", mem_we, 0);
        chk("async_addr", mem_addr, 0);
        chk("async_ready", ld_ready, 0);
        chk("async_stall", cpu_stall, 1);
        chk("async_wdata", mem_wdata, 0);
        chk("async_phase", phase, 0);
        SYS_reset = 1'b1; ld_valid = 1'b0;
        #1;
        chk("rerelease_addr", mem_addr, 0);
        chk("rerelease_we", mem_we, 1);
        tick();
        chk("rerelease_addr1", mem_addr, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Owns the single port of the instruction memory array. Sequences it through three phases: post-reset clear, program load, run.
- During run it arbitrates between the CPU fetch path (read) and the loader/debug patch path (write), stalling fetch while a write occupies the port.
- Sits between the fetch stage, the boot/debug loader and the instruction memory array. The array has a combinational read and a synchronous write.

Parameters:
- DEPTH, 1024, number of 32-bit words in the instruction memory.
- ADDR_W, 10, word-address width; must equal clog2(DEPTH).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip directly to load.
- NOP_INSTR, 32'h00000013, instruction returned to the CPU while stalled or faulted (addi x0,x0,0).

Ports:
- SYS_clk  input  1  system clock; all state changes on the rising edge.
- SYS_reset  input  1  asynchronous, active-low reset.
- cpu_pc  input  32  fetch byte address.
- cpu_instr  output  32  fetched instruction.
- cpu_stall  output  1  fetch must hold its PC this cycle.
- cpu_fault  output  1  cpu_pc is misaligned or out of range.
- ld_valid  input  1  loader offers a write.
- ld_ready  output  1  controller accepts the write this cycle.
- ld_addr  input  32  loader byte address.
- ld_data  input  32  loader write data.
- ld_last  input  1  marks the final word of the initial load.
- ld_restart  input  1  pulse in RUN; re-enters CLEAR/LOAD.
- ld_err  output  1  sticky flag: a loader write was dropped because its address was bad.
- mem_addr  output  ADDR_W  word address to the array.
- mem_we  output  1  array write enable.
- mem_wdata  output  32  array write data.
- mem_rdata  input  32  array combinational read data.
- phase  output  2  current phase: 0 CLEAR, 1 LOAD, 2 RUN.

Behaviour:
- Reset (SYS_reset=0, asynchronous):
  - phase goes to CLEAR, or to LOAD if CLEAR_ON_RESET=0.
  - clr_cnt=0, ld_err=0.
  - Outputs while in reset: cpu_stall=1, cpu_instr=NOP_INSTR, cpu_fault=0, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-operation aborts any phase immediately; a partially cleared or loaded array is not preserved.
- CLEAR:
  - mem_we=1, mem_addr=clr_cnt, mem_wdata=0.
  - clr_cnt increments each cycle.
  - When clr_cnt==DEPTH-1 the next state is LOAD. The phase therefore lasts exactly DEPTH cycles.
  - ld_ready=0, cpu_stall=1, cpu_instr=NOP_INSTR.
- LOAD:
  - ld_ready=1, cpu_stall=1, cpu_instr=NOP_INSTR.
  - On ld_valid&ld_ready: mem_we=1, mem_addr=ld_addr[ADDR_W+1:2], mem_wdata=ld_data.
  - Bad address (ld_addr[1:0]!=0 or ld_addr>>2 >= DEPTH): the write is dropped (mem_we=0), ld_err is set, and the handshake still completes.
  - Handshake with ld_last=1 (good or bad address): next state is RUN.
  - Zero-wait: back-to-back writes are accepted every cycle.
- RUN, no loader write pending:
  - mem_addr=cpu_pc[ADDR_W+1:2], cpu_instr=mem_rdata (same cycle, 0 latency), cpu_stall=0.
- RUN, fault:
  - Condition: cpu_pc[1:0]!=0 or cpu_pc>>2 >= DEPTH.
  - cpu_fault=1, cpu_instr=NOP_INSTR, cpu_stall=0.
  - cpu_fault is combinational and only asserted in RUN.
- RUN, patch write (ld_valid=1):
  - The loader has priority. ld_ready=1 and the write is performed as in LOAD.
  - cpu_stall=1, cpu_instr=NOP_INSTR and cpu_fault=0 for that cycle; the CPU refetches the same PC next cycle.
  - Consecutive patch writes stall consecutive cycles.
  - ld_last is ignored in RUN.
- ld_restart in RUN:
  - Next state is CLEAR (or LOAD if CLEAR_ON_RESET=0), clr_cnt=0.
  - A simultaneous ld_valid is not accepted (ld_ready=0) and no write occurs: restart wins.
  - ld_restart is ignored in CLEAR and LOAD.
- ld_err: cleared only by reset or ld_restart; set by any dropped loader write.
- Widths: clr_cnt is ADDR_W+1 bits so the terminal compare cannot wrap. The range check uses the full 32-bit address, with no truncation before the compare.

Decomposition:
- Shared package imem_pkg:
  - phase encodings PH_CLEAR=2'd0, PH_LOAD=2'd1, PH_RUN=2'd2;
  - NOP_INSTR constant;
  - word-address alignment/range-check function.
- Sub-module: imem_addr_check. Combinational; takes a byte address and returns word index and bad flag. It is instantiated twice, once for the CPU path and once for the loader path.
- The FSM, counter and port mux stay in the top module.

Test Plan:
- Reset → CLEAR: with DEPTH=16, CLEAR_ON_RESET=1, release reset → mem_we=1 with mem_addr 0..15 over exactly 16 cycles, then phase=1 and ld_ready=1; cpu_stall=1 throughout.
- Load then run: write 0xAAAA0001@0x0, 0xBBBB0002@0x4 (ld_last=1) on back-to-back cycles → phase=2 next cycle; cpu_pc=0x4 gives cpu_instr=0xBBBB0002 the same cycle with cpu_stall=0.
- Bad addresses: load ld_addr=0x2 → no write, ld_err=1. In RUN, cpu_pc=0x40 (DEPTH=16) → cpu_fault=1, cpu_instr=0x00000013.
- Patch stall: in RUN with cpu_pc=0x0, pulse ld_valid with 0x12345678@0x0 → cpu_stall=1 and cpu_instr=NOP that cycle; next cycle cpu_instr=0x12345678.
- Restart vs write: ld_restart=1 together with ld_valid=1 → ld_ready=0, no mem_we, phase=0 next cycle, ld_err cleared.
- Async reset mid-LOAD: assert SYS_reset=0 between clock edges → outputs reach their reset values immediately; after release, CLEAR restarts from mem_addr=0.
